// File: rtl/pll_seq_pkg.sv
// ----------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL phase sequencer:
//   - seq_state_e : sequencer state encoding
//   - SEL_*       : counter-select encodings used on cmd_sel / step_sel
//   - NUM_C       : number of post-scale counters (C0..C4) with an offset tally
// ----------------------------------------------------------------------------
package pll_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitAck,
      StGap,
      StSwitch,
      StWaitSw,
      StFinish
   } seq_state_e;

   localparam logic [2:0] SEL_ALL = 3'b000;
   localparam logic [2:0] SEL_M   = 3'b001;
   localparam logic [2:0] SEL_C0  = 3'b010;
   localparam logic [2:0] SEL_C1  = 3'b011;
   localparam logic [2:0] SEL_C2  = 3'b100;
   localparam logic [2:0] SEL_C3  = 3'b101;
   localparam logic [2:0] SEL_C4  = 3'b110;
   localparam logic [2:0] SEL_BAD = 3'b111;

   localparam int unsigned NUM_C = 5;

endpackage

// File: rtl/phase_offset_tracker.sv
// ----------------------------------------------------------------------------
// phase_offset_tracker
// Holds one modulo-PHASE_MOD phase-offset tally per output counter C0..C4.
// Each update strobe moves the selected tally (or all five for SEL_ALL) one
// step up or down with compare-and-wrap arithmetic. SEL_M shifts every output
// together relative to the input, so it leaves the relative tallies alone.
//
// Ports:
//   clk         in   system clock
//   rstn        in   asynchronous active-low reset, clears all tallies
//   i_upd       in   one acked phase step to apply this cycle
//   i_sel       in   counter select of the step (SEL_* encoding)
//   i_up        in   step direction: 1 up, 0 down
//   i_rd_idx    in   readback index 0..4 = C0..C4
//   o_rd_offset out  tally of counter i_rd_idx, 0 for indices above 4
// ----------------------------------------------------------------------------
module phase_offset_tracker
   import pll_seq_pkg::*;
#(
   parameter int unsigned PHASE_MOD = 40,
   parameter int unsigned OFFSET_W  = 6
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                i_upd,
   input  logic [2:0]          i_sel,
   input  logic                i_up,
   input  logic [2:0]          i_rd_idx,
   output logic [OFFSET_W-1:0] o_rd_offset
);

   localparam logic [OFFSET_W-1:0] OFF_MAX = OFFSET_W'(PHASE_MOD - 1);

   logic [OFFSET_W-1:0] r_off [NUM_C];
   logic [NUM_C-1:0]    w_hit;

   always_comb begin
      w_hit = '0;
      unique case (i_sel)
         SEL_ALL:        w_hit = '1;
         SEL_C0:         w_hit[0] = 1'b1;
         SEL_C1:         w_hit[1] = 1'b1;
         SEL_C2:         w_hit[2] = 1'b1;
         SEL_C3:         w_hit[3] = 1'b1;
         SEL_C4:         w_hit[4] = 1'b1;
         SEL_M, SEL_BAD: w_hit = '0;
         default:        w_hit = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < int'(NUM_C); i++) begin
            r_off[i] <= '0;
         end
      end else if (i_upd) begin
         for (int i = 0; i < int'(NUM_C); i++) begin
            if (w_hit[i]) begin
               if (i_up) begin
                  r_off[i] <= (r_off[i] == OFF_MAX) ? '0 : r_off[i] + 1'b1;
               end else begin
                  r_off[i] <= (r_off[i] == '0) ? OFF_MAX : r_off[i] - 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      o_rd_offset = '0;
      for (int i = 0; i < int'(NUM_C); i++) begin
         if (i_rd_idx == 3'(i)) begin
            o_rd_offset = r_off[i];
         end
      end
   end

endmodule

// File: rtl/pll_phase_sequencer.sv
// ----------------------------------------------------------------------------
// pll_phase_sequencer
// Command sequencer in front of the PLL phase-step / clock-switch engine.
// Accepts one host command at a time, splits a multi-step command into single
// acknowledged step requests separated by GAP_CYCLES idle cycles, and keeps a
// per-counter phase-offset tally for host readback.
//
// Build option:
//   PHASE_TIMEOUT_EN  when defined, a watchdog aborts a command if step_ack or
//                     clksw_ack does not arrive within TIMEOUT_CYCLES of the
//                     request (err + done pulse). Undefined: waits forever.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_sel, cmd_up        counter select and direction
//   cmd_nsteps             number of steps (0 completes immediately)
//   cmd_clkswitch          request an input-clock toggle instead of steps
//   step_req/step_ack      one-cycle step request / completion pulses
//   step_sel, step_up      latched select / direction, stable while busy
//   clksw_req/clksw_ack    one-cycle clock-switch request / completion pulses
//   busy, done, err        status (done/err are one-cycle pulses)
//   rd_idx, rd_offset      combinational offset readback, C0..C4
// ----------------------------------------------------------------------------
module pll_phase_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned NSTEP_W    = 8,
   parameter int unsigned PHASE_MOD  = 40,
   parameter int unsigned OFFSET_W   = 6,
   parameter int unsigned GAP_CYCLES = 16
`ifdef PHASE_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd_sel,
   input  logic                cmd_up,
   input  logic [NSTEP_W-1:0]  cmd_nsteps,
   input  logic                cmd_clkswitch,
   output logic                step_req,
   output logic [2:0]          step_sel,
   output logic                step_up,
   input  logic                step_ack,
   output logic                clksw_req,
   input  logic                clksw_ack,
   output logic                busy,
   output logic                done,
   output logic                err,
   input  logic [2:0]          rd_idx,
   output logic [OFFSET_W-1:0] rd_offset
);

   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   // Counter runs GAP_CYCLES-1 down to 0, giving GAP_CYCLES cycles in StGap.
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

`ifdef PHASE_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
   // The request cycle counts as cycle 0, so done lands TIMEOUT_CYCLES after it.
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] r_wd;
   logic            w_timeout;
   assign w_timeout = (r_wd == WD_LAST);
`endif

   seq_state_e         r_state;
   logic               r_step_req;
   logic               r_clksw_req;
   logic               r_busy;
   logic               r_done;
   logic               r_err;
   logic [2:0]         r_step_sel;
   logic               r_step_up;
   logic [NSTEP_W-1:0] r_remaining;
   logic [GAP_W-1:0]   r_gap;
   logic               w_step_upd;

   // Acks are only meaningful while waiting for one; stray acks are dropped.
   assign w_step_upd = (r_state == StWaitAck) && step_ack;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= StIdle;
         r_step_req  <= 1'b0;
         r_clksw_req <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_step_sel  <= SEL_ALL;
         r_step_up   <= 1'b1;
         r_remaining <= '0;
         r_gap       <= '0;
`ifdef PHASE_TIMEOUT_EN
         r_wd        <= '0;
`endif
      end else begin
         // Pulse outputs default low; they are raised on entry to their state.
         r_step_req  <= 1'b0;
         r_clksw_req <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (cmd_valid) begin
                  if (cmd_clkswitch) begin
                     r_busy      <= 1'b1;
                     r_clksw_req <= 1'b1;
                     r_state     <= StSwitch;
                  end else begin
                     r_step_sel  <= cmd_sel;
                     r_step_up   <= cmd_up;
                     r_remaining <= cmd_nsteps;
                     if ((cmd_sel == SEL_BAD) || (cmd_nsteps == '0)) begin
                        r_done  <= 1'b1;
                        r_err   <= (cmd_sel == SEL_BAD);
                        r_state <= StFinish;
                     end else begin
                        r_busy     <= 1'b1;
                        r_step_req <= 1'b1;
                        r_state    <= StIssue;
                     end
                  end
               end
            end
            StIssue: begin
`ifdef PHASE_TIMEOUT_EN
               r_wd <= WD_W'(1);
`endif
               r_state <= StWaitAck;
            end
            StWaitAck: begin
               if (step_ack) begin
                  r_remaining <= r_remaining - 1'b1;
                  if (r_remaining == NSTEP_W'(1)) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= StFinish;
                  end else begin
                     r_gap   <= GAP_LOAD;
                     r_state <= StGap;
                  end
               end
`ifdef PHASE_TIMEOUT_EN
               else if (w_timeout) begin
                  // Abandon the unacked step and everything after it.
                  r_remaining <= '0;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_err       <= 1'b1;
                  r_state     <= StFinish;
               end else begin
                  r_wd <= r_wd + 1'b1;
               end
`endif
            end
            StGap: begin
               if (r_gap == '0) begin
                  r_step_req <= 1'b1;
                  r_state    <= StIssue;
               end else begin
                  r_gap <= r_gap - 1'b1;
               end
            end
            StSwitch: begin
`ifdef PHASE_TIMEOUT_EN
               r_wd <= WD_W'(1);
`endif
               r_state <= StWaitSw;
            end
            StWaitSw: begin
               if (clksw_ack) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= StFinish;
               end
`ifdef PHASE_TIMEOUT_EN
               else if (w_timeout) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_state <= StFinish;
               end else begin
                  r_wd <= r_wd + 1'b1;
               end
`endif
            end
            StFinish: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign cmd_ready = (r_state == StIdle);
   assign step_req  = r_step_req;
   assign step_sel  = r_step_sel;
   assign step_up   = r_step_up;
   assign clksw_req = r_clksw_req;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;

   phase_offset_tracker #(
      .PHASE_MOD (PHASE_MOD),
      .OFFSET_W  (OFFSET_W)
   ) u_tracker (
      .clk         (clk),
      .rstn        (rstn),
      .i_upd       (w_step_upd),
      .i_sel       (r_step_sel),
      .i_up        (r_step_up),
      .i_rd_idx    (rd_idx),
      .o_rd_offset (rd_offset)
   );

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pll_phase_sequencer
// Directed self-checking bench for pll_phase_sequencer (GAP_CYCLES=16,
// PHASE_MOD=40). With PHASE_TIMEOUT_EN defined the watchdog scenario is
// exercised, otherwise the indefinite-wait behaviour is.
// ----------------------------------------------------------------------------
module tb_pll_phase_sequencer;

   localparam int unsigned NSTEP_W    = 8;
   localparam int unsigned PHASE_MOD  = 40;
   localparam int unsigned OFFSET_W   = 6;
   localparam int unsigned GAP_CYCLES = 16;

   logic                clk;
   logic                rstn;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [2:0]          cmd_sel;
   logic                cmd_up;
   logic [NSTEP_W-1:0]  cmd_nsteps;
   logic                cmd_clkswitch;
   logic                step_req;
   logic [2:0]          step_sel;
   logic                step_up;
   logic                step_ack;
   logic                clksw_req;
   logic                clksw_ack;
   logic                busy;
   logic                done;
   logic                err;
   logic [2:0]          rd_idx;
   logic [OFFSET_W-1:0] rd_offset;

   logic auto_ack = 1'b0;
   logic man_ack  = 1'b0;
   assign step_ack = auto_ack | man_ack;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int n_req  = 0;
   int n_clksw = 0;
   int n_done = 0;
   int n_err  = 0;
   int req_log [16];
   bit ack_en = 1'b0;
   int ack_delay = 4;
   int ack_cnt = 0;

   pll_phase_sequencer #(
      .NSTEP_W    (NSTEP_W),
      .PHASE_MOD  (PHASE_MOD),
      .OFFSET_W   (OFFSET_W),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_sel       (cmd_sel),
      .cmd_up        (cmd_up),
      .cmd_nsteps    (cmd_nsteps),
      .cmd_clkswitch (cmd_clkswitch),
      .step_req      (step_req),
      .step_sel      (step_sel),
      .step_up       (step_up),
      .step_ack      (step_ack),
      .clksw_req     (clksw_req),
      .clksw_ack     (clksw_ack),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .rd_idx        (rd_idx),
      .rd_offset     (rd_offset)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (step_req) begin
         req_log[n_req % 16] = cyc;
         n_req++;
      end
      if (clksw_req) n_clksw++;
      if (done) n_done++;
      if (err) n_err++;
   end

   // Engine model: ack a step_req ack_delay cycles after it (ack high in cycle s+ack_delay).
   always @(negedge clk) begin
      auto_ack = 1'b0;
      if (ack_cnt != 0) begin
         ack_cnt--;
         if (ack_cnt == 0) auto_ack = 1'b1;
      end
      if (step_req && ack_en) ack_cnt = ack_delay;
   end

   task automatic do_reset;
      rstn = 1'b0;
      cmd_valid = 1'b0;
      man_ack = 1'b0;
      clksw_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   // Returns in the first cycle after acceptance.
   task automatic send_cmd(input logic [2:0] sel, input logic up, input logic [7:0] n,
                           input logic sw);
      bit acc;
      cmd_sel = sel; cmd_up = up; cmd_nsteps = n; cmd_clkswitch = sw; cmd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         acc = cmd_ready;
         @(posedge clk); #1;
         if (acc) break;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (done) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_req(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (step_req) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      repeat (2) @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (step_req !== 1'b0 || clksw_req !== 1'b0) begin errors++;
         $display("FAIL rst_req: got %b%b want 00", step_req, clksw_req); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++;
         $display("FAIL rst_done_err: got %b%b want 00", done, err); end
      checks++; if (step_sel !== 3'b000 || step_up !== 1'b1) begin errors++;
         $display("FAIL rst_sel_up: got %b/%b want 000/1", step_sel, step_up); end
      #1 rstn = 1'b1;
      @(posedge clk); #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
      for (int i = 0; i < 8; i++) begin
         rd_idx = 3'(i); #1;
         checks++; if (rd_offset !== '0) begin errors++;
            $display("FAIL rst_offset idx=%0d: got %0d want 0", i, rd_offset); end
      end
   endtask

   task automatic test_c0_steps;
      int b_req, b_done, b_err;
      int exp [5];
      bit ok;
      do_reset();
      ack_en = 1'b1; ack_delay = 4;
      b_req = n_req; b_done = n_done; b_err = n_err;
      send_cmd(3'b010, 1'b1, 8'd3, 1'b0);
      checks++; if (busy !== 1'b1 || step_sel !== 3'b010 || step_up !== 1'b1) begin errors++;
         $display("FAIL c0_latch: got busy=%b sel=%b up=%b want 1/010/1", busy, step_sel, step_up); end
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL c0_done_timeout: got no done want done"); end
      repeat (2) @(posedge clk); #1;
      checks++; if (n_req - b_req != 3) begin errors++;
         $display("FAIL c0_req_count: got %0d want 3", n_req - b_req); end
      checks++; if (req_log[(b_req + 1) % 16] - req_log[b_req % 16] != 21) begin errors++;
         $display("FAIL c0_spacing1: got %0d want 21", req_log[(b_req + 1) % 16] - req_log[b_req % 16]); end
      checks++; if (req_log[(b_req + 2) % 16] - req_log[(b_req + 1) % 16] != 21) begin errors++;
         $display("FAIL c0_spacing2: got %0d want 21",
                  req_log[(b_req + 2) % 16] - req_log[(b_req + 1) % 16]); end
      checks++; if (n_done - b_done != 1 || n_err - b_err != 0) begin errors++;
         $display("FAIL c0_done_err: got %0d/%0d want 1/0", n_done - b_done, n_err - b_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL c0_busy_end: got %b want 0", busy); end
      exp = '{3, 0, 0, 0, 0};
      for (int i = 0; i < 5; i++) begin
         rd_idx = 3'(i); #1;
         checks++; if (rd_offset !== OFFSET_W'(exp[i])) begin errors++;
            $display("FAIL c0_offset idx=%0d: got %0d want %0d", i, rd_offset, exp[i]); end
      end
   endtask

   task automatic test_all_wrap;
      int exp [5];
      bit ok;
      do_reset();
      ack_en = 1'b1; ack_delay = 4;
      send_cmd(3'b000, 1'b0, 8'd1, 1'b0);
      wait_done(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL all_done_timeout: got no done want done"); end
      for (int i = 0; i < 5; i++) begin
         rd_idx = 3'(i); #1;
         checks++; if (rd_offset !== 6'd39) begin errors++;
            $display("FAIL all_wrap idx=%0d: got %0d want 39", i, rd_offset); end
      end
      rd_idx = 3'd7; #1;
      checks++; if (rd_offset !== '0) begin errors++;
         $display("FAIL rd_idx7: got %0d want 0", rd_offset); end
      send_cmd(3'b011, 1'b1, 8'd2, 1'b0);
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL c1_done_timeout: got no done want done"); end
      exp = '{39, 1, 39, 39, 39};
      for (int i = 0; i < 5; i++) begin
         rd_idx = 3'(i); #1;
         checks++; if (rd_offset !== OFFSET_W'(exp[i])) begin errors++;
            $display("FAIL c1_offset idx=%0d: got %0d want %0d", i, rd_offset, exp[i]); end
      end
   endtask

   task automatic test_clkswitch;
      int b_req, b_sw, b_done;
      int exp [5];
      ack_en = 1'b1;
      @(posedge clk); #1;
      b_req = n_req; b_sw = n_clksw; b_done = n_done;
      send_cmd(3'b010, 1'b1, 8'd5, 1'b1);
      checks++; if (clksw_req !== 1'b1 || step_req !== 1'b0 || busy !== 1'b1) begin errors++;
         $display("FAIL sw_req: got sw=%b step=%b busy=%b want 1/0/1", clksw_req, step_req, busy); end
      repeat (3) @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++;
         $display("FAIL sw_wait: got done=%b busy=%b want 0/1", done, busy); end
      clksw_ack = 1'b1;
      @(posedge clk); #1;
      clksw_ack = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL sw_done: got %b want 1", done); end
      repeat (2) @(posedge clk); #1;
      checks++; if (n_clksw - b_sw != 1 || n_req - b_req != 0 || n_done - b_done != 1) begin errors++;
         $display("FAIL sw_counts: got sw=%0d req=%0d done=%0d want 1/0/1",
                  n_clksw - b_sw, n_req - b_req, n_done - b_done); end
      exp = '{39, 1, 39, 39, 39};
      for (int i = 0; i < 5; i++) begin
         rd_idx = 3'(i); #1;
         checks++; if (rd_offset !== OFFSET_W'(exp[i])) begin errors++;
            $display("FAIL sw_offset idx=%0d: got %0d want %0d", i, rd_offset, exp[i]); end
      end
   endtask

   task automatic test_illegal_and_zero;
      int b_req;
      @(posedge clk); #1;
      b_req = n_req;
      send_cmd(3'b111, 1'b1, 8'd4, 1'b0);
      checks++; if (done !== 1'b1 || err !== 1'b1 || cmd_ready !== 1'b0) begin errors++;
         $display("FAIL bad_finish: got done=%b err=%b rdy=%b want 1/1/0", done, err, cmd_ready); end
      @(posedge clk); #1;
      checks++; if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin errors++;
         $display("FAIL bad_ready2: got rdy=%b done=%b err=%b want 1/0/0", cmd_ready, done, err); end
      send_cmd(3'b010, 1'b1, 8'd0, 1'b0);
      checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++;
         $display("FAIL zero_finish: got done=%b err=%b want 1/0", done, err); end
      @(posedge clk); #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_ready2: got %b want 1", cmd_ready); end
      repeat (3) @(posedge clk); #1;
      checks++; if (n_req - b_req != 0) begin errors++;
         $display("FAIL bad_zero_noreq: got %0d want 0", n_req - b_req); end
   endtask

   task automatic test_spurious_ack;
      int b_req, b_done, s;
      int exp [5];
      bit ok;
      ack_en = 1'b0;
      @(posedge clk); #1;
      b_req = n_req; b_done = n_done;
      man_ack = 1'b1; @(posedge clk); #1; man_ack = 1'b0;
      rd_idx = 3'd2; #1;
      checks++; if (rd_offset !== 6'd39 || busy !== 1'b0) begin errors++;
         $display("FAIL idle_ack: got off=%0d busy=%b want 39/0", rd_offset, busy); end
      send_cmd(3'b100, 1'b1, 8'd2, 1'b0);
      s = cyc;
      checks++; if (step_req !== 1'b1) begin errors++; $display("FAIL sp_req1: got %b want 1", step_req); end
      @(posedge clk); #1;
      @(posedge clk); #1; man_ack = 1'b1;
      @(posedge clk); #1; man_ack = 1'b0;
      rd_idx = 3'd2; #1;
      checks++; if (rd_offset !== 6'd0) begin errors++;
         $display("FAIL sp_wrap_up: got %0d want 0", rd_offset); end
      @(posedge clk); #1;
      @(posedge clk); #1; man_ack = 1'b1;
      @(posedge clk); #1; man_ack = 1'b0;
      rd_idx = 3'd2; #1;
      checks++; if (rd_offset !== 6'd0 || busy !== 1'b1 || n_done != b_done) begin errors++;
         $display("FAIL gap_ack: got off=%0d busy=%b done=%0d want 0/1/0", rd_offset, busy, n_done - b_done); end
      wait_req(40, ok);
      checks++; if (!ok || cyc - s != 19) begin errors++;
         $display("FAIL sp_req2_time: got %0d want 19", cyc - s); end
      @(posedge clk); #1; man_ack = 1'b1;
      @(posedge clk); #1; man_ack = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL sp_done: got %b want 1", done); end
      @(posedge clk); #1;
      checks++; if (n_req - b_req != 2) begin errors++;
         $display("FAIL sp_req_count: got %0d want 2", n_req - b_req); end
      exp = '{39, 1, 1, 39, 39};
      for (int i = 0; i < 5; i++) begin
         rd_idx = 3'(i); #1;
         checks++; if (rd_offset !== OFFSET_W'(exp[i])) begin errors++;
            $display("FAIL sp_offset idx=%0d: got %0d want %0d", i, rd_offset, exp[i]); end
      end
   endtask

   task automatic test_reset_mid;
      int b_req, b_done;
      bit ok;
      ack_en = 1'b0;
      @(posedge clk); #1;
      send_cmd(3'b010, 1'b0, 8'd5, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1; man_ack = 1'b1;
      @(posedge clk); #1; man_ack = 1'b0;
      rd_idx = 3'd0; #1;
      checks++; if (rd_offset !== 6'd38) begin errors++;
         $display("FAIL mid_step1: got %0d want 38", rd_offset); end
      wait_req(40, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mid_req2: got no step_req want step_req"); end
      @(posedge clk); #1;
      rstn = 1'b0; #1;
      checks++; if (busy !== 1'b0 || step_req !== 1'b0 || cmd_ready !== 1'b1) begin errors++;
         $display("FAIL mid_rst_ctl: got busy=%b req=%b rdy=%b want 0/0/1", busy, step_req, cmd_ready); end
      checks++; if (step_sel !== 3'b000 || step_up !== 1'b1) begin errors++;
         $display("FAIL mid_rst_sel: got %b/%b want 000/1", step_sel, step_up); end
      for (int i = 0; i < 5; i++) begin
         rd_idx = 3'(i); #1;
         checks++; if (rd_offset !== '0) begin errors++;
            $display("FAIL mid_rst_offset idx=%0d: got %0d want 0", i, rd_offset); end
      end
      @(posedge clk); #1; rstn = 1'b1;
      b_req = n_req; b_done = n_done;
      @(posedge clk); #1; man_ack = 1'b1;
      @(posedge clk); #1; man_ack = 1'b0;
      repeat (30) @(posedge clk); #1;
      rd_idx = 3'd0; #1;
      checks++; if (n_req != b_req || n_done != b_done || busy !== 1'b0 || rd_offset !== '0) begin errors++;
         $display("FAIL late_ack: got req=%0d done=%0d busy=%b off=%0d want 0/0/0/0",
                  n_req - b_req, n_done - b_done, busy, rd_offset); end
   endtask

`ifdef PHASE_TIMEOUT_EN
   task automatic test_timeout;
      int b_req, b_err, s;
      bit ok;
      ack_en = 1'b0;
      @(posedge clk); #1;
      b_req = n_req; b_err = n_err;
      send_cmd(3'b010, 1'b1, 8'd3, 1'b0);
      s = cyc;
      wait_done(1200, ok);
      checks++; if (!ok || cyc - s != 1024) begin errors++;
         $display("FAIL to_time: got %0d want 1024", cyc - s); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err); end
      @(posedge clk); #1;
      rd_idx = 3'd0; #1;
      checks++; if (rd_offset !== '0 || n_req - b_req != 1 || n_err - b_err != 1) begin errors++;
         $display("FAIL to_state: got off=%0d req=%0d err=%0d want 0/1/1",
                  rd_offset, n_req - b_req, n_err - b_err); end
   endtask
`else
   task automatic test_no_timeout;
      int b_done, bad;
      ack_en = 1'b0;
      @(posedge clk); #1;
      b_done = n_done; bad = 0;
      send_cmd(3'b010, 1'b1, 8'd3, 1'b0);
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk); #1;
         if (busy !== 1'b1) bad++;
      end
      checks++; if (bad != 0 || n_done != b_done) begin errors++;
         $display("FAIL hang_busy: got drops=%0d done=%0d want 0/0", bad, n_done - b_done); end
      do_reset();
   endtask
`endif

   initial begin
      rstn = 1'b0;
      cmd_valid = 1'b0; cmd_sel = 3'b000; cmd_up = 1'b1; cmd_nsteps = '0; cmd_clkswitch = 1'b0;
      clksw_ack = 1'b0; rd_idx = 3'd0;
      test_reset();
      test_c0_steps();
      test_all_wrap();
      test_clkswitch();
      test_illegal_and_zero();
      test_spurious_ack();
      test_reset_mid();
`ifdef PHASE_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pll_phase_sequencer.md
Name: pll_phase_sequencer

Overview:
Command sequencer directly upstream of the PLL phase-step/clock-switch engine.
- Accepts host commands (counter select, direction, step count, or clock-switch) over a valid/ready handshake.
- Breaks each command into single-step requests to the downstream engine, one at a time, each acknowledged.
- Keeps a per-counter phase-offset tally (modulo PHASE_MOD) for readback by the host register interface.

Parameters:
- NSTEP_W, 8: width of cmd_nsteps; max 255 steps per command.
- PHASE_MOD, 40: phase steps per full output period; offsets wrap modulo this value.
- OFFSET_W, 6: width of each offset tally; must satisfy 2^OFFSET_W >= PHASE_MOD.
- GAP_CYCLES, 16: idle clk cycles enforced between step_ack and the next step_req.
- TIMEOUT_CYCLES, 1024: watchdog limit on step_ack / clksw_ack (only with PHASE_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_sel  in  3  counter select: 000 all, 001 M, 010..110 C0..C4, 111 illegal
- cmd_up  in  1  direction: 1 up, 0 down
- cmd_nsteps  in  NSTEP_W  number of steps
- cmd_clkswitch  in  1  request input-clock toggle instead of phase steps
- step_req  out  1  one-cycle pulse: start one phase step
- step_sel  out  3  counter select to engine; stable while busy
- step_up  out  1  direction to engine; stable while busy
- step_ack  in  1  one-cycle pulse: engine finished the step
- clksw_req  out  1  one-cycle pulse: start clock switch
- clksw_ack  in  1  one-cycle pulse: switch finished
- busy  out  1  command in progress
- done  out  1  one-cycle pulse: command complete
- err  out  1  one-cycle pulse: illegal select, or timeout
- rd_idx  in  3  offset readback index 0..4 = C0..C4
- rd_offset  out  OFFSET_W  combinational offset of counter rd_idx; 0 if rd_idx > 4

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1 after release; step_req=0, clksw_req=0, busy=0, done=0, err=0, step_sel=000, step_up=1; remaining=0; all offsets=0.
- Reset mid-command abandons the command. Downstream is not notified; a late ack after reset is ignored.

State machine: IDLE, ISSUE, WAIT_ACK, GAP, SWITCH, WAIT_SW, FINISH.

IDLE:
- cmd_ready=1. Accept on cmd_valid & cmd_ready.
- On accept, latch step_sel, step_up and remaining=cmd_nsteps; set busy=1.
- cmd_clkswitch=1 has precedence: go to SWITCH and ignore the step fields.
- Else if cmd_sel is 111, or cmd_nsteps=0: go to FINISH. Illegal select also pulses err.
- Else go to ISSUE.

ISSUE:
- step_req=1 for exactly this cycle, then go to WAIT_ACK.

WAIT_ACK:
- Sample step_ack only in this state; acks in any other state are ignored.
- On ack: update offsets, decrement remaining.
- If remaining is now 0, go to FINISH. Otherwise load the gap counter and go to GAP.

GAP:
- Count GAP_CYCLES cycles, then go to ISSUE.
- step_ack to next step_req spacing is exactly GAP_CYCLES+1 clk.

SWITCH:
- clksw_req=1 for one cycle, then go to WAIT_SW.

WAIT_SW:
- On clksw_ack, go to FINISH. Offsets are unchanged.

FINISH:
- done=1 for one cycle, busy=0, return to IDLE.
- cmd_ready is re-asserted the cycle after FINISH.
- Minimum command-to-command latency: 2 cycles for a zero-step command.

Offset update on each acked step:
- Select C0..C4: update that counter only.
- Select all: update all five counters.
- Select M: no tally change (M shifts all outputs relative to the input, not to each other).
- Up: offset = offset+1, wrapping PHASE_MOD-1 to 0.
- Down: offset = offset-1, wrapping 0 to PHASE_MOD-1.
- Arithmetic is unsigned, compare-and-wrap; no modulo operator.

Optional Feature:
- Macro: PHASE_TIMEOUT_EN.
- Defined: a watchdog counts cycles in WAIT_ACK / WAIT_SW. On reaching TIMEOUT_CYCLES without an ack: pulse err, skip the remaining steps, go to FINISH (done still pulses). The offset reflects only acked steps.
- Undefined: no watchdog; the sequencer waits indefinitely. err comes only from illegal select.

Decomposition:
- Package pll_seq_pkg holds:
  - state enum;
  - select encodings SEL_ALL=3'b000, SEL_M=3'b001, SEL_C0..SEL_C4=3'b010..3'b110, SEL_BAD=3'b111;
  - NUM_C=5.
- Sub-module phase_offset_tracker:
  - holds the five mod-PHASE_MOD registers;
  - inputs: update strobe, sel, up, rd_idx; output: rd_offset.

Test Plan:
- Reset then cmd sel=010, up=1, nsteps=3, ack each step_req 4 cycles later -> exactly 3 step_req pulses spaced 4+1+GAP_CYCLES apart; done once; C0 offset=3; others 0.
- From reset, sel=000, up=0, nsteps=1 -> all five offsets=39 (wrap with PHASE_MOD=40); then sel=011, up=1, nsteps=2 -> C1=1, others 39.
- cmd_clkswitch=1 with sel=010, nsteps=5 -> one clksw_req, no step_req; done after clksw_ack; offsets unchanged.
- sel=111, nsteps=4 -> err and done pulse; no step_req; cmd_ready back in 2 cycles. nsteps=0 -> done with no err.
- Spurious step_ack in IDLE and GAP -> ignored; remaining and offsets unchanged. Assert rstn low in WAIT_ACK of step 2/5 -> immediate reset values; a subsequent ack does nothing.
- PHASE_TIMEOUT_EN defined, never ack -> err and done pulse at TIMEOUT_CYCLES after step_req; offset unchanged. Macro undefined -> busy held 5000 cycles.
